// File: rtl/ibex_axi_pkg.sv
// Shared AXI4 request/response structs for the SRAM slave: 4-bit id, 32-bit address and data.
package ibex_axi_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } axi_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } axi_w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } axi_b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   w_ready;
        axi_b_t b;
        logic   b_valid;
        logic   ar_ready;
        axi_r_t r;
        logic   r_valid;
    } axi_rsp_t;

endpackage

// File: rtl/ibex_axi_sram_if.sv
// AXI request/response bundle between a core-side master and the SRAM slave.
interface ibex_axi_sram_if;
    import ibex_axi_pkg::*;

    axi_req_t req;
    axi_rsp_t rsp;

    modport master (output req, input rsp);
    modport slave  (input req, output rsp);
endinterface

// File: rtl/ibex_axi_sram.sv
// AXI4 slave in front of a single-port 32-bit SRAM; one transaction at a time, one word per cycle.
module ibex_axi_sram #(
    parameter type         axi_req_t = ibex_axi_pkg::axi_req_t,
    parameter type         axi_rsp_t = ibex_axi_pkg::axi_rsp_t,
    parameter logic [31:0] BaseAddr  = 32'h0000_0000,
    parameter int unsigned MemWords  = 16384,
    localparam int unsigned MemAw    = $clog2(MemWords)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  axi_req_t         axi_req_i,
    output axi_rsp_t         axi_rsp_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [MemAw-1:0] mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic [3:0]       mem_be_o,
    input  logic [31:0]      mem_rdata_i
);

    localparam logic [32:0] MemBytes = 33'(MemWords) << 2;

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_REQ, RD_CAP, RD_RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  id_q, id_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;
    logic        err_q, err_d;      // sticky for writes, per-beat for reads
    logic [31:0] rdata_q, rdata_d;
    logic        prio_q, prio_d;    // 0: write wins a tie, 1: read wins

    logic [31:0] off, word_off, next_addr;
    logic        in_range, grant_w, grant_r;
    logic        unused_bits;

    // Beat decode: range check against the served window and next-beat address
    always_comb begin
        off       = addr_q - BaseAddr;
        word_off  = off >> 2;
        in_range  = (addr_q >= BaseAddr) && ({1'b0, off} < MemBytes);
        next_addr = (burst_q == 2'b00) ? addr_q : addr_q + (32'd1 << size_q);
    end

    assign mem_addr_o  = word_off[MemAw-1:0];
    assign unused_bits = ^{axi_req_i.w.last, off};

    // Transaction FSM: arbitration, beat sequencing and all handshake outputs
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        burst_d     = burst_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        prio_d      = prio_q;
        axi_rsp_o   = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'hF;
        mem_wdata_o = axi_req_i.w.data;
        grant_w     = axi_req_i.aw_valid && (!axi_req_i.ar_valid || !prio_q);
        grant_r     = axi_req_i.ar_valid && !grant_w;
        case (state_q)
            IDLE: begin
                axi_rsp_o.aw_ready = grant_w;
                axi_rsp_o.ar_ready = grant_r;
                if (grant_w) begin
                    id_d    = axi_req_i.aw.id;
                    addr_d  = axi_req_i.aw.addr;
                    cnt_d   = axi_req_i.aw.len;
                    size_d  = axi_req_i.aw.size;
                    burst_d = axi_req_i.aw.burst;
                    err_d   = 1'b0;
                    prio_d  = ~prio_q;
                    state_d = WR_DATA;
                end else if (grant_r) begin
                    id_d    = axi_req_i.ar.id;
                    addr_d  = axi_req_i.ar.addr;
                    cnt_d   = axi_req_i.ar.len;
                    size_d  = axi_req_i.ar.size;
                    burst_d = axi_req_i.ar.burst;
                    err_d   = 1'b0;
                    prio_d  = ~prio_q;
                    state_d = RD_REQ;
                end
            end
            WR_DATA: begin
                axi_rsp_o.w_ready = 1'b1;
                mem_be_o          = axi_req_i.w.strb;
                if (axi_req_i.w_valid) begin
                    if (in_range) begin
                        mem_req_o = 1'b1;
                        mem_we_o  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    // beat count alone ends the burst; w.last is not trusted
                    if (cnt_q == 8'd0) begin
                        state_d = WR_RESP;
                    end else begin
                        cnt_d  = cnt_q - 8'd1;
                        addr_d = next_addr;
                    end
                end
            end
            WR_RESP: begin
                axi_rsp_o.b_valid = 1'b1;
                axi_rsp_o.b.id    = id_q;
                axi_rsp_o.b.resp  = err_q ? 2'b11 : 2'b00;
                if (axi_req_i.b_ready) state_d = IDLE;
            end
            RD_REQ: begin
                mem_req_o = in_range;
                err_d     = !in_range;
                state_d   = RD_CAP;
            end
            RD_CAP: begin
                rdata_d = err_q ? 32'h0 : mem_rdata_i;
                state_d = RD_RESP;
            end
            RD_RESP: begin
                axi_rsp_o.r_valid = 1'b1;
                axi_rsp_o.r.id    = id_q;
                axi_rsp_o.r.data  = rdata_q;
                axi_rsp_o.r.resp  = err_q ? 2'b11 : 2'b00;
                axi_rsp_o.r.last  = (cnt_q == 8'd0);
                if (axi_req_i.r_ready) begin
                    if (cnt_q == 8'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        addr_d  = next_addr;
                        state_d = RD_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any in-flight transaction
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            prio_q  <= prio_d;
        end
    end

endmodule

// File: tb/tb_ibex_axi_sram.sv
// Scoreboard bench: stimulus pushes expected B/R/SRAM-write items, a negedge monitor pops and compares.
module tb_ibex_axi_sram;
    import ibex_axi_pkg::*;

    localparam int MW = 64;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ibex_axi_sram_if bus ();

    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [3:0]    mem_be;

    ibex_axi_sram #(.BaseAddr(32'h0), .MemWords(MW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .axi_req_i(bus.req), .axi_rsp_o(bus.rsp),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
    );

    // SRAM model: byte-enabled write, read data one cycle after the strobe
    logic [31:0] sram [MW];
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (mem_be[i]) sram[mem_addr][8*i +: 8] = mem_wdata[8*i +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    typedef struct { logic [AW-1:0] a; logic [31:0] d; logic [3:0] be; } wr_t;
    axi_b_t b_q [$];
    axi_r_t r_q [$];
    wr_t    w_q [$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s", nm);
    endtask

    // Monitor
    axi_b_t eb;
    axi_r_t er, r_hold;
    wr_t    ew;
    logic   stall_q = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (bus.rsp.b_valid && bus.req.b_ready) begin
                if (b_q.size() == 0) fail("b_unexpected");
                else begin
                    eb = b_q.pop_front();
                    chk("b_id", bus.rsp.b.id, eb.id);
                    chk("b_resp", bus.rsp.b.resp, eb.resp);
                end
            end
            if (bus.rsp.r_valid) begin
                if (stall_q) chk("r_stable", bus.rsp.r, r_hold);
                if (bus.req.r_ready) begin
                    if (r_q.size() == 0) fail("r_unexpected");
                    else begin
                        er = r_q.pop_front();
                        chk("r_id", bus.rsp.r.id, er.id);
                        chk("r_data", bus.rsp.r.data, er.data);
                        chk("r_resp", bus.rsp.r.resp, er.resp);
                        chk("r_last", bus.rsp.r.last, er.last);
                    end
                end
                stall_q = !bus.req.r_ready;
                r_hold  = bus.rsp.r;
            end else begin
                stall_q = 1'b0;
            end
            if (mem_req && mem_we) begin
                if (w_q.size() == 0) fail("memwr_unexpected");
                else begin
                    ew = w_q.pop_front();
                    chk("mem_addr", mem_addr, ew.a);
                    chk("mem_wdata", mem_wdata, ew.d);
                    chk("mem_be", mem_be, ew.be);
                end
            end
        end
    end

    // Stimulus helpers
    task automatic set_aw(logic [3:0] id, logic [31:0] a, logic [7:0] len, logic [1:0] bt);
        bus.req.aw.id = id; bus.req.aw.addr = a; bus.req.aw.len = len;
        bus.req.aw.size = 3'd2; bus.req.aw.burst = bt; bus.req.aw_valid = 1'b1;
    endtask

    task automatic set_ar(logic [3:0] id, logic [31:0] a, logic [7:0] len, logic [1:0] bt);
        bus.req.ar.id = id; bus.req.ar.addr = a; bus.req.ar.len = len;
        bus.req.ar.size = 3'd2; bus.req.ar.burst = bt; bus.req.ar_valid = 1'b1;
    endtask

    task automatic wait_aw();
        int t = 0;
        @(negedge clk);
        while (!bus.rsp.aw_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) fail("aw_timeout");
        @(posedge clk); #1 bus.req.aw_valid = 1'b0;
    endtask

    task automatic wait_ar();
        int t = 0;
        @(negedge clk);
        while (!bus.rsp.ar_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) fail("ar_timeout");
        @(posedge clk); #1 bus.req.ar_valid = 1'b0;
    endtask

    task automatic do_w(logic [31:0] d, logic [3:0] s, logic l);
        int t = 0;
        bus.req.w.data = d; bus.req.w.strb = s; bus.req.w.last = l; bus.req.w_valid = 1'b1;
        @(negedge clk);
        while (!bus.rsp.w_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) fail("w_timeout");
        @(posedge clk); #1 bus.req.w_valid = 1'b0;
    endtask

    task automatic wait_b(output int lat);
        lat = 1;
        bus.req.b_ready = 1'b1;
        @(negedge clk);
        while (!bus.rsp.b_valid && lat < 50) begin @(negedge clk); lat++; end
        if (lat >= 50) fail("b_timeout");
        @(posedge clk); #1 bus.req.b_ready = 1'b0;
    endtask

    // Collect n read beats; lat = cycles from AR handshake to first r_valid
    task automatic rd_beats(int n, bit toggle, output int lat);
        int beats = 0;
        int cyc = 0;
        lat = 0;
        bus.req.r_ready = !toggle;
        while (beats < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.rsp.r_valid && lat == 0) lat = cyc;
            if (bus.rsp.r_valid && bus.req.r_ready) beats++;
            @(posedge clk); #1;
            if (toggle) bus.req.r_ready = ~bus.req.r_ready;
        end
        if (beats < n) fail("r_timeout");
        bus.req.r_ready = 1'b0;
    endtask

    int lat;

    initial begin
        bus.req = '0;
        for (int i = 0; i < MW; i++) sram[i] = 32'h0;
        sram[4]  = 32'hCAFE_F00D;
        sram[5]  = 32'hAABB_CCDD;
        sram[8]  = 32'hA0A0_0008;
        sram[9]  = 32'hA0A0_0009;
        sram[10] = 32'hA0A0_000A;
        sram[11] = 32'hA0A0_000B;
        sram[17] = 32'h1717_1717;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_b_valid", bus.rsp.b_valid, 0);
        chk("rst_r_valid", bus.rsp.r_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Arbitration: tie -> write first, next tie -> read
        set_aw(4'd1, 32'h40, 8'd0, 2'b01);
        set_ar(4'd2, 32'h44, 8'd0, 2'b01);
        @(negedge clk);
        chk("arb1_aw_ready", bus.rsp.aw_ready, 1);
        chk("arb1_ar_ready", bus.rsp.ar_ready, 0);
        @(posedge clk); #1 bus.req.aw_valid = 1'b0;
        w_q.push_back('{a: 6'd16, d: 32'h4040_4040, be: 4'hF});
        b_q.push_back('{id: 4'd1, resp: 2'b00});
        do_w(32'h4040_4040, 4'hF, 1'b1);
        set_aw(4'd6, 32'h48, 8'd0, 2'b01);
        wait_b(lat);
        @(negedge clk);
        chk("arb2_ar_ready", bus.rsp.ar_ready, 1);
        chk("arb2_aw_ready", bus.rsp.aw_ready, 0);
        @(posedge clk); #1 bus.req.ar_valid = 1'b0;
        r_q.push_back('{id: 4'd2, data: 32'h1717_1717, resp: 2'b00, last: 1'b1});
        rd_beats(1, 1'b0, lat);
        wait_aw();
        w_q.push_back('{a: 6'd18, d: 32'h4848_4848, be: 4'hF});
        b_q.push_back('{id: 4'd6, resp: 2'b00});
        do_w(32'h4848_4848, 4'hF, 1'b1);
        wait_b(lat);

        // Single read
        set_ar(4'd5, 32'h10, 8'd0, 2'b01);
        wait_ar();
        r_q.push_back('{id: 4'd5, data: 32'hCAFE_F00D, resp: 2'b00, last: 1'b1});
        rd_beats(1, 1'b0, lat);
        chk("rd_latency", lat, 3);

        // Single write
        set_aw(4'd3, 32'h10, 8'd0, 2'b01);
        wait_aw();
        w_q.push_back('{a: 6'd4, d: 32'hDEAD_BEEF, be: 4'hF});
        b_q.push_back('{id: 4'd3, resp: 2'b00});
        do_w(32'hDEAD_BEEF, 4'hF, 1'b1);
        wait_b(lat);
        chk("wr_latency", lat, 1);

        // Partial-strobe write then readbacks
        set_aw(4'd7, 32'h14, 8'd0, 2'b01);
        wait_aw();
        w_q.push_back('{a: 6'd5, d: 32'h1122_3344, be: 4'b0101});
        b_q.push_back('{id: 4'd7, resp: 2'b00});
        do_w(32'h1122_3344, 4'b0101, 1'b1);
        wait_b(lat);
        set_ar(4'd9, 32'h10, 8'd0, 2'b01);
        wait_ar();
        r_q.push_back('{id: 4'd9, data: 32'hDEAD_BEEF, resp: 2'b00, last: 1'b1});
        rd_beats(1, 1'b0, lat);
        set_ar(4'd9, 32'h14, 8'd0, 2'b01);
        wait_ar();
        r_q.push_back('{id: 4'd9, data: 32'hAA22_CC44, resp: 2'b00, last: 1'b1});
        rd_beats(1, 1'b0, lat);

        // INCR burst with r_ready toggling
        set_ar(4'd4, 32'h20, 8'd3, 2'b01);
        wait_ar();
        r_q.push_back('{id: 4'd4, data: 32'hA0A0_0008, resp: 2'b00, last: 1'b0});
        r_q.push_back('{id: 4'd4, data: 32'hA0A0_0009, resp: 2'b00, last: 1'b0});
        r_q.push_back('{id: 4'd4, data: 32'hA0A0_000A, resp: 2'b00, last: 1'b0});
        r_q.push_back('{id: 4'd4, data: 32'hA0A0_000B, resp: 2'b00, last: 1'b1});
        rd_beats(4, 1'b1, lat);
        chk("burst_latency", lat, 3);

        // FIXED burst stays on one word
        set_ar(4'd8, 32'h10, 8'd1, 2'b00);
        wait_ar();
        r_q.push_back('{id: 4'd8, data: 32'hDEAD_BEEF, resp: 2'b00, last: 1'b0});
        r_q.push_back('{id: 4'd8, data: 32'hDEAD_BEEF, resp: 2'b00, last: 1'b1});
        rd_beats(2, 1'b0, lat);

        // Write crossing the top of the window: beat 0 lands, beat 1 decode error
        set_aw(4'hA, 32'hFC, 8'd1, 2'b01);
        wait_aw();
        w_q.push_back('{a: 6'd63, d: 32'h0BAD_F00D, be: 4'hF});
        b_q.push_back('{id: 4'hA, resp: 2'b11});
        do_w(32'h0BAD_F00D, 4'hF, 1'b0);
        do_w(32'h1234_5678, 4'hF, 1'b1);
        wait_b(lat);

        // Out-of-range read returns zero with decode error
        set_ar(4'hB, 32'h100, 8'd0, 2'b01);
        wait_ar();
        r_q.push_back('{id: 4'hB, data: 32'h0, resp: 2'b11, last: 1'b1});
        rd_beats(1, 1'b0, lat);

        // Reset while a burst beat is waiting in RD_RESP
        set_ar(4'hC, 32'h20, 8'd3, 2'b01);
        wait_ar();
        bus.req.r_ready = 1'b0;
        begin
            int t = 0;
            @(negedge clk);
            while (!bus.rsp.r_valid && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) fail("rst_burst_timeout");
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_r_valid", bus.rsp.r_valid, 0);
        chk("rst_mid_mem_req", mem_req, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        set_ar(4'hD, 32'h24, 8'd0, 2'b01);
        wait_ar();
        r_q.push_back('{id: 4'hD, data: 32'hA0A0_0009, resp: 2'b00, last: 1'b1});
        rd_beats(1, 1'b0, lat);
        chk("post_rst_latency", lat, 3);

        repeat (3) @(posedge clk);
        chk("b_q_empty", b_q.size(), 0);
        chk("r_q_empty", r_q.size(), 0);
        chk("w_q_empty", w_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

endmodule

// File: doc/ibex_axi_sram.md
IBEX_AXI_SRAM -- requirements
Module: ibex_axi_sram

Interface
REQ-001 SHALL have parameter axi_req_t, default project axi_req_t, meaning AXI4 request struct (AW/W/AR plus valids and readys).
REQ-002 SHALL have parameter axi_rsp_t, default project axi_rsp_t, meaning AXI4 response struct (B/R plus valids and readys).
REQ-003 SHALL have parameter BaseAddr, default 32'h0000_0000, meaning first byte address served.
REQ-004 SHALL have parameter MemWords, default 16384, meaning number of 32-bit words served; MemAw = $clog2(MemWords).
REQ-005 SHALL have port clk_i  input  1  clock, rising-edge.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port axi_req_i  input  axi_req_t  AXI slave request from the core-side AXI master (id 4b, addr 32b, data 32b, strb 4b).
REQ-008 SHALL have port axi_rsp_o  output  axi_rsp_t  AXI slave response.
REQ-009 SHALL have port mem_req_o  output  1  SRAM access strobe, one word per cycle.
REQ-010 SHALL have port mem_we_o  output  1  SRAM write enable.
REQ-011 SHALL have port mem_addr_o  output  MemAw  SRAM word address.
REQ-012 SHALL have port mem_wdata_o  output  32  SRAM write data.
REQ-013 SHALL have port mem_be_o  output  4  SRAM byte enables.
REQ-014 SHALL have port mem_rdata_i  input  32  SRAM read data, valid exactly one cycle after a read strobe.

Function
REQ-015 SHALL implement FSM states IDLE, WR_DATA, WR_RESP, RD_REQ, RD_CAP, RD_RESP.
REQ-016 IDLE: aw_ready and ar_ready SHALL each be 1 only for the granted valid channel; all other readys and valids SHALL be 0 in every other state unless stated below.
REQ-017 Arbitration in IDLE: only one valid -> that channel is granted; both valid -> priority alternates, starting with write after reset, and toggles after each granted transaction.
REQ-018 Accepting AW or AR SHALL latch id, addr, len, size, burst; beat counter = len (0..255).
REQ-019 Beat address: FIXED keeps addr; INCR and WRAP both add (1 << size) per beat, wrapping modulo 2^32.
REQ-020 Per-beat in-range check: addr in [BaseAddr, BaseAddr + 4*MemWords); word address = (addr - BaseAddr) >> 2, truncated to MemAw.
REQ-021 WR_DATA: w_ready = 1; on a W handshake with an in-range beat, mem_req_o=1, mem_we_o=1, mem_wdata_o=w.data, mem_be_o=w.strb in the same cycle; out-of-range beats are accepted without a strobe and set a sticky decode-error flag.
REQ-022 WR_DATA: after the handshake of the beat where the counter is 0, SHALL go to WR_RESP; w.last is ignored for termination.
REQ-023 WR_RESP: b_valid=1, b.id = latched id, b.resp = 2'b11 if the sticky flag is set else 2'b00; held until b_ready, then go to IDLE.
REQ-024 RD_REQ: in range -> mem_req_o=1, mem_we_o=0, mem_be_o=4'hF for one cycle; out of range -> no strobe. Then go to RD_CAP.
REQ-025 RD_CAP: register mem_rdata_i, or 32'h0 if out of range; then go to RD_RESP.
REQ-026 RD_RESP: r_valid=1, r.data = registered word, r.id = latched id, r.resp = 2'b11 if out of range else 2'b00, r.last = (counter==0); all held stable until r_ready.
REQ-027 RD_RESP handshake: if last, go to IDLE; otherwise decrement the counter, advance the address, and go to RD_REQ.
REQ-028 Read timing: AR handshake at cycle 0 -> mem strobe at cycle 1 -> r_valid at cycle 3; beats are at least 3 cycles apart.
REQ-029 Write timing: AW handshake at cycle 0 -> earliest W accepted at cycle 1 -> b_valid at cycle 2 for a single beat.
REQ-030 mem_req_o SHALL never assert outside WR_DATA and RD_REQ; at most one outstanding transaction at any time.

Reset
REQ-031 rst_ni low SHALL immediately force state IDLE, counters and sticky flag to 0, and the registered read data to 0.
REQ-032 rst_ni low SHALL force all rsp valids, mem_req_o and mem_we_o to 0, and reset the arbitration priority to write; an in-flight transaction is dropped with no response.

Verification
REQ-033 Single write: AW addr 0x10, id 3, len 0; W data 0xDEADBEEF, strb 0xF -> mem_addr_o=4, mem_we_o=1 in the W cycle; b_valid two cycles after AW with id 3, resp 00.
REQ-034 Single read: SRAM word 4 = 0xCAFEF00D; AR addr 0x10, id 5 -> r_valid at cycle 3 with data 0xCAFEF00D, id 5, last=1, resp 00.
REQ-035 INCR read burst: len 3 at 0x20 with r_ready toggling -> words 8,9,10,11 are returned in order, last only on the 4th beat, and data stays stable while stalled.
REQ-036 Decode error: AW at BaseAddr + 4*MemWords - 4, len 1, INCR -> first beat is written and the second is not; b.resp = 11.
REQ-037 Arbitration: AW and AR valid in the same cycle, twice in a row -> the write is granted first, then the read.
REQ-038 Reset mid-burst: rst_ni low during RD_RESP -> r_valid is 0 immediately; after release the block is in IDLE and accepts a new AR normally.
